// File: rtl/afifo_pkg.sv
// Shared definitions for the async FIFO wrapper's read-side logic.
package afifo_pkg;

  localparam int RD_LAT_MIN  = 1;
  localparam int RD_LAT_MAX  = 4;
  localparam int WRAP_DATA_W = 528;

  typedef logic [WRAP_DATA_W-1:0] stream_word_t;

  // Pointer width for a buffer of 'depth' entries; never narrower than 1 bit.
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic bit cfg_ok(input int lat, input int depth);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX) && (depth >= lat + 1);
  endfunction

endpackage

// File: rtl/rd_latency_pipe.sv
// Tracks outstanding FIFO reads: bit i set means a word lands i+1 cycles after issue.
module rd_latency_pipe #(
  parameter int LAT   = 1,
  parameter int CNT_W = $clog2(LAT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in,
  output logic             o_tail,
  output logic [CNT_W-1:0] o_cnt
);

  logic [LAT-1:0] r_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_in;
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < LAT; i++) o_cnt = o_cnt + CNT_W'(r_pipe[i]);
  end

  assign o_tail = r_pipe[LAT-1];

endmodule

// File: rtl/afifo_rd_stream_adapter.sv
// Read-side drain: issues safe FIFO reads, absorbs read latency, emits valid/ready stream.
module afifo_rd_stream_adapter
  import afifo_pkg::*;
#(
  parameter int DATA_WIDTH = 528,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             fifo_rdempty,
  input  logic [DATA_WIDTH-1:0]            fifo_data_out,
  output logic                             fifo_read_en,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   occupancy,
  output logic [31:0]                      pop_count
);

  localparam int PTR_W = ptr_w(BUF_DEPTH);
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int INF_W = $clog2(RD_LATENCY + 1);
  localparam int SUM_W = OCC_W + INF_W + 1;

  if (!cfg_ok(RD_LATENCY, BUF_DEPTH)) begin : g_bad_cfg
    $error("afifo_rd_stream_adapter: illegal RD_LATENCY/BUF_DEPTH");
  end

  logic                  r_run;
  logic [OCC_W-1:0]      r_occ;
  logic [PTR_W-1:0]      r_rd_ptr, r_wr_ptr;
  logic [31:0]           r_pop_count;
  logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];

  logic                  w_tail, w_cap, w_pop, w_rd_en;
  logic [INF_W-1:0]      w_infl;
  logic [SUM_W-1:0]      w_sum;

  rd_latency_pipe #(.LAT(RD_LATENCY), .CNT_W(INF_W)) u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_in   (w_rd_en),
    .o_tail (w_tail),
    .o_cnt  (w_infl)
  );

  // Reserve a slot for every inflight word so a capture can never overflow.
  always_comb begin
    w_sum   = SUM_W'(r_occ) + SUM_W'(w_infl);
    w_rd_en = r_run && !fifo_rdempty && (w_sum < SUM_W'(BUF_DEPTH));
  end

  assign w_cap        = w_tail;
  assign w_pop        = out_valid && out_ready;
  assign fifo_read_en = w_rd_en;
  assign out_valid    = (r_occ != '0);
  assign out_data     = r_buf[r_rd_ptr];
  assign occupancy    = r_occ;
  assign pop_count    = r_pop_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run       <= 1'b0;
      r_occ       <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_pop_count <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_cap) r_wr_ptr <= (r_wr_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr    <= (r_rd_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
        r_pop_count <= r_pop_count + 32'd1;
      end
      case ({w_cap, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Storage is deliberately unreset; out_valid gates its visibility.
  always_ff @(posedge clk) begin
    if (w_cap) r_buf[r_wr_ptr] <= fifo_data_out;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    w_cap |-> (r_occ != OCC_W'(BUF_DEPTH)));
  a_legal_read: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_read_en |-> !fifo_rdempty);
  a_hold_data: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> $stable(out_data));

endmodule

// File: tb/tb_afifo_rd_stream_adapter.sv
// Directed bench for the read-side stream adapter, plus a randomized ready run on a deeper config.
module tb_afifo_rd_stream_adapter;
  import afifo_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: default config (latency 1, depth 3)
  logic         rd_en_a, valid_a, ready_a;
  stream_word_t data_in_a, data_out_a;
  logic [1:0]   occ_a;
  logic [31:0]  popc_a;
  int           fifo_na;
  int           rda_cnt;
  stream_word_t qa[$];
  wire          empty_a = (fifo_na == 0);

  afifo_rd_stream_adapter #(.DATA_WIDTH(528), .RD_LATENCY(1), .BUF_DEPTH(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .fifo_rdempty(empty_a), .fifo_data_out(data_in_a),
    .fifo_read_en(rd_en_a), .out_valid(valid_a), .out_ready(ready_a),
    .out_data(data_out_a), .occupancy(occ_a), .pop_count(popc_a)
  );

  // DUT B: latency 2, depth 4
  logic         rd_en_b, valid_b, ready_b;
  stream_word_t data_in_b, data_out_b, sb1;
  logic [2:0]   occ_b;
  logic [31:0]  popc_b;
  int           fifo_nb;
  stream_word_t qb[$];
  stream_word_t expq[$];
  wire          empty_b = (fifo_nb == 0);

  afifo_rd_stream_adapter #(.DATA_WIDTH(528), .RD_LATENCY(2), .BUF_DEPTH(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .fifo_rdempty(empty_b), .fifo_data_out(data_in_b),
    .fifo_read_en(rd_en_b), .out_valid(valid_b), .out_ready(ready_b),
    .out_data(data_out_b), .occupancy(occ_b), .pop_count(popc_b)
  );

  // FIFO models: read data appears RD_LATENCY cycles after the read cycle
  always @(posedge clk) begin
    if (rd_en_a && qa.size() > 0) begin
      data_in_a <= qa.pop_front();
      fifo_na   <= fifo_na - 1;
      rda_cnt   <= rda_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (rd_en_b && qb.size() > 0) begin
      sb1     <= qb.pop_front();
      fifo_nb <= fifo_nb - 1;
    end
    data_in_b <= sb1;
  end

  int npass = 0;
  int nchk  = 0;

  task automatic chk(input string tag, input logic [527:0] obs, input logic [527:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push_a(input stream_word_t w);
    qa.push_back(w);
    fifo_na = fifo_na + 1;
  endtask

  initial begin
    int base, got;
    stream_word_t w;
    rst_n = 1'b0; ready_a = 1'b1; ready_b = 1'b0;
    fifo_na = 0; fifo_nb = 0; rda_cnt = 0;
    data_in_a = '0; data_in_b = '0; sb1 = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", valid_a, 0);
    chk("rst_rden", rd_en_a, 0);
    chk("rst_occ", occ_a, 0);
    chk("rst_popc", popc_a, 0);

    // release with 10 words preloaded, ready held high
    for (int i = 1; i <= 10; i++) push_a(stream_word_t'(i));
    rst_n = 1'b1;
    #1 chk("rel_rden_first", rd_en_a, 0);
    @(negedge clk);
    chk("rel_rden_second", rd_en_a, 1);
    chk("rel_valid_n1", valid_a, 0);
    @(negedge clk);
    chk("rel_valid_n2", valid_a, 0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("stream_valid", valid_a, 1);
      chk("stream_data", data_out_a, stream_word_t'(i));
    end
    @(negedge clk);
    chk("stream_done_valid", valid_a, 0);
    chk("stream_popc", popc_a, 10);
    chk("stream_occ", occ_a, 0);

    // backpressure with 5 words available
    ready_a = 1'b0;
    base = rda_cnt;
    for (int i = 1; i <= 5; i++) push_a(stream_word_t'(i));
    repeat (6) @(negedge clk);
    chk("bp_reads", rda_cnt - base, 3);
    chk("bp_occ", occ_a, 3);
    chk("bp_rden", rd_en_a, 0);
    chk("bp_data", data_out_a, 1);
    @(negedge clk);
    chk("bp_hold_data", data_out_a, 1);
    chk("bp_hold_valid", valid_a, 1);
    ready_a = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      chk("bp_drain_valid", valid_a, 1);
      chk("bp_drain_data", data_out_a, stream_word_t'(i));
      @(negedge clk);
    end
    chk("bp_drain_end", valid_a, 0);
    chk("bp_popc", popc_a, 15);

    // FIFO empties with one read still inflight
    push_a(stream_word_t'(32'h21));
    push_a(stream_word_t'(32'h22));
    #1 chk("emp_rden_m0", rd_en_a, 1);
    @(negedge clk);
    chk("emp_rden_m1", rd_en_a, 1);
    @(negedge clk);
    chk("emp_rden_drop", rd_en_a, 0);
    chk("emp_occ_m2", occ_a, 1);
    chk("emp_data0", data_out_a, 32'h21);
    @(negedge clk);
    chk("emp_data1", data_out_a, 32'h22);
    chk("emp_valid1", valid_a, 1);
    @(negedge clk);
    chk("emp_valid_end", valid_a, 0);
    chk("emp_occ_end", occ_a, 0);
    chk("emp_popc", popc_a, 17);

    // async reset mid-operation with two words buffered
    ready_a = 1'b0;
    for (int i = 0; i < 5; i++) push_a(stream_word_t'(32'h31 + i));
    repeat (3) @(negedge clk);
    chk("mid_occ_pre", occ_a, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", valid_a, 0);
    chk("mid_occ", occ_a, 0);
    chk("mid_popc", popc_a, 0);
    chk("mid_rden", rd_en_a, 0);
    qa.delete();
    fifo_na = 0;
    @(negedge clk);
    rst_n = 1'b1;
    ready_a = 1'b1;
    @(negedge clk);

    // latency 2 / depth 4: 1000 words against random ready
    for (int i = 0; i < 1000; i++) begin
      w = stream_word_t'({$urandom(), $urandom()});
      qb.push_back(w);
      expq.push_back(w);
    end
    fifo_nb = 1000;
    got = 0;
    for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
      @(negedge clk);
      ready_b = 1'($urandom_range(0, 1));
      if (valid_b && ready_b) begin
        chk("rand_data", data_out_b, expq.pop_front());
        got++;
      end
    end
    chk("rand_count", got, 1000);
    @(negedge clk);
    ready_b = 1'b0;
    chk("rand_popc", popc_b, 1000);
    chk("rand_occ", occ_b, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
